// File: rtl/cfg_shadow_decoder_if.sv
// Pad-side write port of cfg_shadow_decoder: strobe plus address/data held stable while valid is high.
interface cfg_shadow_decoder_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 10
);
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output valid, addr, data);
  modport slave  (input  valid, addr, data);
endinterface

// File: rtl/cfg_shadow_decoder.sv
// Pad-driven configuration decoder: synchronised strobe, shadow registers with atomic commit,
// serial shadow readback, lock mode and a sticky error flag.
module cfg_shadow_decoder #(
  parameter int unsigned        AW       = 5,
  parameter int unsigned        DW       = 10,
  parameter int unsigned        NREG     = 24,
  parameter int unsigned        CMD_ADDR = 2**AW - 1,
  parameter logic [NREG*DW-1:0] RST_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cfg_shadow_decoder_if.slave  pad,
  output logic [NREG*DW-1:0]   cfg_q,
  output logic                 commit_pulse,
  output logic                 busy,
  output logic                 dout,
  output logic                 locked,
  output logic                 err
);

  typedef enum logic {IDLE, SHIFT} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_COMMIT, OP_READBACK, OP_LOCK} op_e;

  state_e             state_q, state_d;
  logic               v1_q, v2_q, v3_q;
  logic [NREG*DW-1:0] shadow_q, shadow_d;
  logic [NREG*DW-1:0] active_q, active_d;
  logic [DW-1:0]      shift_q, shift_d;
  logic [DW-1:0]      cnt_q, cnt_d;
  logic               commit_q, commit_d;
  logic               busy_q, busy_d;
  logic               dout_q, dout_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;

  logic               stb;
  logic               is_cmd;
  logic               wr_hit;
  logic               rb_hit;
  logic [DW-1:0]      rb_val;
  op_e                op;
  logic [DW-3:0]      arg;

  assign stb    = v2_q & ~v3_q;
  assign op     = op_e'(pad.data[1:0]);
  assign arg    = pad.data[DW-1:2];
  assign is_cmd = (32'(pad.addr) == CMD_ADDR);

  // Address/argument range checks done by match so widths never alias.
  always_comb begin
    wr_hit = 1'b0;
    rb_hit = 1'b0;
    rb_val = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(pad.addr) == i) wr_hit = 1'b1;
      if (32'(arg) == i) begin
        rb_hit = 1'b1;
        rb_val = shadow_q[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    busy_d   = busy_q;
    dout_d   = dout_q;
    locked_d = locked_q;
    err_d    = err_q;

    if (state_q == SHIFT) begin
      if (cnt_q == DW'(DW - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        dout_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q << 1;
        dout_d  = shift_q[DW-2];
      end
    end

    if (stb) begin
      if (is_cmd && op == OP_NOP) begin
        err_d = 1'b0;
      end else if (busy_q) begin
        err_d = 1'b1;
      end else if (is_cmd) begin
        case (op)
          OP_COMMIT: begin
            if (locked_q) begin
              err_d = 1'b1;
            end else begin
              active_d = shadow_q;
              commit_d = 1'b1;
            end
          end
          OP_READBACK: begin
            if (rb_hit) begin
              state_d = SHIFT;
              busy_d  = 1'b1;
              shift_d = rb_val;
              dout_d  = rb_val[DW-1];
              cnt_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_LOCK: locked_d = 1'b1;
          default: ;
        endcase
      end else if (wr_hit) begin
        if (locked_q) begin
          err_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NREG; i++) begin
            if (32'(pad.addr) == i) shadow_d[i*DW +: DW] = pad.data;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
      shift_q  <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      v1_q     <= pad.valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      shadow_q <= shadow_d;
      active_q <= active_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign cfg_q        = active_q;
  assign commit_pulse = commit_q;
  assign busy         = busy_q;
  assign dout         = dout_q;
  assign locked       = locked_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cfg_shadow_decoder.sv
// Directed bench for cfg_shadow_decoder; readback bits are checked against a scoreboard queue.
module tb_cfg_shadow_decoder;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 10;
  localparam int unsigned NREG = 24;
  localparam int unsigned CMD  = 31;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREG*DW-1:0]  cfg;
  logic                commit_pulse, busy, dout, locked, err;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int rb_cycles = 0;
  logic prev_pulse = 1'b0;
  logic [NREG*DW-1:0] prev_cfg = '0;
  logic [DW-1:0] snap0, snap1;
  logic exp_q[$];

  cfg_shadow_decoder_if #(.AW(AW), .DW(DW)) pad_if ();

  cfg_shadow_decoder #(.AW(AW), .DW(DW), .NREG(NREG), .CMD_ADDR(CMD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad          (pad_if.slave),
    .cfg_q        (cfg),
    .commit_pulse (commit_pulse),
    .busy         (busy),
    .dout         (dout),
    .locked       (locked),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return cfg[i*DW +: DW];
  endfunction

  function automatic int cmd(input int op, input int arg);
    return (arg << 2) | op;
  endfunction

  task automatic pad_write(input int a, input int d, input int hold);
    @(negedge clk);
    pad_if.addr  = AW'(a);
    pad_if.data  = DW'(d);
    pad_if.valid = 1'b1;
    repeat (hold) @(negedge clk);
    pad_if.valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic readback(input int arg, input int val, input int hold);
    logic [DW-1:0] v;
    v = DW'(val);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(v[i]);
    rb_cycles = 0;
    pad_write(CMD, cmd(2, arg), hold);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_cycles"}, rb_cycles, DW);
    check({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  // Scoreboard and output monitor.
  always @(negedge clk) begin
    if (busy) begin
      rb_cycles++;
      check("rb_qsize", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rb_dout", dout, exp_q.pop_front());
    end
    if (commit_pulse) begin
      pulse_cnt++;
      snap0 = reg_of(0);
      snap1 = reg_of(1);
      check("pulse_width", prev_pulse, 0);
    end
    if (rst_n && cfg != prev_cfg) check("cfg_change_pulse", commit_pulse, 1);
    prev_pulse = commit_pulse;
    prev_cfg   = cfg;
  end

  initial begin
    pad_if.valid = 1'b0;
    pad_if.addr  = '0;
    pad_if.data  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_pulse", commit_pulse, 0);
    check("rst_cfg_zero", cfg == '0, 1);
    rst_n = 1'b1;

    pad_write(0, 'h155, 4);
    pad_write(1, 'h2AA, 4);
    check("precommit_reg0", reg_of(0), 0);
    check("precommit_reg1", reg_of(1), 0);
    check("precommit_pulses", pulse_cnt, 0);
    pad_write(CMD, cmd(1, 0), 4);
    check("commit_reg0", reg_of(0), 'h155);
    check("commit_reg1", reg_of(1), 'h2AA);
    check("commit_pulses", pulse_cnt, 1);
    check("commit_snap0", snap0, 'h155);
    check("commit_snap1", snap1, 'h2AA);

    pad_write(2, 'h3FF, 20);
    readback(2, 'h3FF, 20);
    wait_idle("rb_held");
    check("rb_held_err", err, 0);
    check("rb_shadow_not_active", reg_of(2), 0);

    pad_write(25, 'h001, 4);
    check("bad_addr_err", err, 1);
    pad_write(CMD, cmd(0, 0), 4);
    check("nop_clears_err", err, 0);
    rb_cycles = 0;
    pad_write(CMD, cmd(2, 30), 4);
    check("bad_rb_err", err, 1);
    check("bad_rb_busy", busy, 0);
    check("bad_rb_cycles", rb_cycles, 0);
    pad_write(CMD, cmd(0, 0), 4);

    pad_write(5, 'h201, 4);
    readback(5, 'h201, 4);
    pad_write(4, 'h155, 4);
    wait_idle("rb_201");
    check("busy_write_err", err, 1);
    pad_write(CMD, cmd(0, 0), 4);
    readback(4, 'h000, 4);
    wait_idle("rb_dropped");

    pad_write(3, 'h0AB, 4);
    pad_write(CMD, cmd(3, 0), 4);
    check("lock_set", locked, 1);
    check("lock_err_clear", err, 0);
    pad_write(3, 'h0F0, 4);
    check("locked_write_err", err, 1);
    pad_write(CMD, cmd(0, 0), 4);
    check("locked_nop_err", err, 0);
    pad_write(CMD, cmd(1, 0), 4);
    check("locked_commit_err", err, 1);
    check("locked_commit_pulses", pulse_cnt, 1);
    check("locked_reg3", reg_of(3), 0);
    check("locked_still", locked, 1);
    readback(3, 'h0AB, 4);
    wait_idle("rb_locked");

    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    pad_if.addr  = AW'(CMD);
    pad_if.data  = DW'(cmd(2, 0));
    pad_if.valid = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    check("midshift_busy", busy, 1);
    @(negedge clk);
    pad_if.valid = 1'b0;
    check("midshift_dout", dout, 1);
    check("midshift_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dout", dout, 0);
    check("arst_locked", locked, 0);
    check("arst_err", err, 0);
    check("arst_cfg_zero", cfg == '0, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cfg_shadow_decoder.md
Name: cfg_shadow_decoder

Overview:
Parametrised successor to the sandbox pad-driven configuration decoder. It accepts slow tester-driven writes (valid/addr/data on pads) through a synchroniser and edge detector, and stages them in shadow registers. Shadow values are transferred atomically to the active configuration outputs on a COMMIT command. It adds serial readback, a lock mode and sticky error reporting. It sits between the west pad crossbar and the macro configuration inputs (PLL ratios, TRNG/noise selects).

Parameters:
AW, 5, address width
DW, 10, data/register width (min 4)
NREG, 24, number of configuration registers (NREG < 2**AW - 1)
CMD_ADDR, 2**AW-1, command address
RST_VAL, {NREG*DW{1'b0}}, reset value of shadow and active registers

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  pad strobe, asynchronous to clk; write requested on its rising edge
addr  in  AW  pad address, stable while valid is high
data  in  DW  pad data, stable while valid is high
cfg_q  out  NREG*DW  active registers, reg i at [i*DW +: DW]
commit_pulse  out  1  one-cycle pulse when active registers update
busy  out  1  readback shift in progress
dout  out  1  serial readback data, MSB first
locked  out  1  lock state
err  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): shadow = active = RST_VAL; commit_pulse, busy, dout, locked, err = 0; synchroniser flops = 0; FSM = IDLE.
- Sync: valid passes through 2 flops (v1, v2) plus a delay flop v3. stb = v2 & ~v3. addr/data are sampled when stb = 1, and are stable by then through the pad protocol.
- Latency: a shadow write is visible internally on the 3rd clk edge after valid is first sampled high. A level held high produces exactly one stb.
- Decode on stb:
  - addr < NREG: shadow[addr] <= data, unless locked, in which case ignore and set err.
  - NREG <= addr < CMD_ADDR: ignore and set err.
  - addr == CMD_ADDR, op = data[1:0], arg = data[DW-1:2]:
    - op 0 NOP: clears err.
    - op 1 COMMIT: if !locked, active <= shadow (all registers in the same edge) and commit_pulse = 1 the following cycle. If locked, set err.
    - op 2 READBACK: if arg < NREG, load shift reg with shadow[arg] and go to SHIFT. If arg >= NREG, set err and stay IDLE.
    - op 3 LOCK: locked <= 1. Only reset clears it.
- FSM:
  - IDLE: busy = 0, dout = 0.
  - SHIFT: busy = 1. dout = shift[DW-1], then shift left each cycle. A DW-wide counter counts DW cycles, then the FSM returns to IDLE. dout is bit DW-1 in the first SHIFT cycle and bit 0 in the last.
- Any stb while busy is ignored entirely, with no register or lock change, and sets err. Exception: NOP still clears err.
- Readback returns the shadow value, not the active value.
- A reset mid-SHIFT aborts immediately: busy = 0, dout = 0.
- cfg_q changes only on COMMIT or reset. It never glitches on shadow writes.
- err is set and cleared only as above. A set and a clear never occur in the same cycle, because there is a single stb per cycle.

Test Plan:
- Reset, write addr 0 = 0x155, addr 1 = 0x2AA, no commit -> cfg_q reg0/reg1 stay 0, commit_pulse stays 0. Commit -> reg0 = 0x155, reg1 = 0x2AA in the same edge, one-cycle commit_pulse.
- Hold valid high for 20 cycles with addr 2, data 0x3FF -> exactly one shadow write. Readback arg 2 -> busy high for 10 cycles, dout = ten 1s, then busy = 0.
- Write addr 25 (NREG = 24) -> err = 1, no register change. NOP -> err = 0. READBACK arg 30 -> err = 1, busy stays 0.
- LOCK, then write addr 3 = 0x0F0 and COMMIT -> locked = 1, cfg_q unchanged, err = 1. Readback arg 3 shows the pre-lock shadow value.
- Start readback of 0x201, issue a write to addr 4 during SHIFT -> write dropped, err = 1, dout sequence 1,0,0,0,0,0,0,0,0,1 intact.
- Assert rst_n = 0 mid-SHIFT and after commits -> busy, dout, locked, err = 0 immediately, and cfg_q = RST_VAL.
